// File: rtl/wavetable_reader.sv
// wavetable_reader
//   Reads one interpolated sample for each of four voices per frame.
//   For each voice: look up {wfm_l, wfm_r, factor} in that voice's wavetable
//   RAM, read both waveform samples from the shared ROM at the voice's phase,
//   then blend them linearly by factor/256.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   sample_req            frame start, honoured only while idle
//   wtb_pos[23:0]         6-bit wavetable position per voice
//   phase[31:0]           8-bit phase per voice
//   wtb_ram_re[3:0]       one-hot per-voice RAM read enable
//   wtb_ram_addr_r[5:0]   RAM read address (clamped to the last entry)
//   wtb_ram_wfm_l_r, wtb_ram_wfm_r_r, wtb_ram_factor_r  RAM data, 1 cycle latency
//   wfm_rom_re, wfm_rom_addr[15:0], wfm_rom_data[7:0]  ROM port, 1 cycle latency
//   sample_out, sample_voice, sample_valid  interpolated result and strobe
//   busy, done            frame in progress / one-cycle end-of-frame pulse
module wavetable_reader #(
    parameter int unsigned WTB_RAM_SIZE = 61
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_req,
    input  logic [23:0] wtb_pos,
    input  logic [31:0] phase,
    output logic [3:0]  wtb_ram_re,
    output logic [5:0]  wtb_ram_addr_r,
    input  logic [7:0]  wtb_ram_wfm_l_r,
    input  logic [7:0]  wtb_ram_wfm_r_r,
    input  logic [7:0]  wtb_ram_factor_r,
    output logic        wfm_rom_re,
    output logic [15:0] wfm_rom_addr,
    input  logic [7:0]  wfm_rom_data,
    output logic [7:0]  sample_out,
    output logic [1:0]  sample_voice,
    output logic        sample_valid,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] MaxAddr = 6'(WTB_RAM_SIZE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdWtb,
        StRdL,
        StRdR,
        StCalc,
        StNext,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] pos_q, pos_d;
    logic [31:0] phase_q, phase_d;
    logic [1:0]  voice_q, voice_d;
    logic [7:0]  wfm_l_q, wfm_l_d;
    logic [7:0]  wfm_r_q, wfm_r_d;
    logic [7:0]  factor_q, factor_d;
    logic [7:0]  sample_l_q, sample_l_d;
    logic [7:0]  sample_out_q, sample_out_d;
    logic [1:0]  sample_voice_q, sample_voice_d;
    logic        sample_valid_q, sample_valid_d;

    logic [5:0]         cur_pos;
    logic [7:0]         cur_phase;
    logic [5:0]         cur_addr;
    logic signed [8:0]  diff;
    logic signed [17:0] prod;

    assign cur_pos   = pos_q[6*voice_q +: 6];
    assign cur_phase = phase_q[8*voice_q +: 8];
    assign cur_addr  = (cur_pos > MaxAddr) ? MaxAddr : cur_pos;

    // Signed blend: the shifted product never pushes sample_l outside 0..255.
    assign diff = $signed({1'b0, wfm_rom_data}) - $signed({1'b0, sample_l_q});
    assign prod = 18'(diff) * $signed({10'b0, factor_q});

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        phase_d        = phase_q;
        voice_d        = voice_q;
        wfm_l_d        = wfm_l_q;
        wfm_r_d        = wfm_r_q;
        factor_d       = factor_q;
        sample_l_d     = sample_l_q;
        sample_out_d   = sample_out_q;
        sample_voice_d = sample_voice_q;
        sample_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_req) begin
                    pos_d   = wtb_pos;
                    phase_d = phase;
                    voice_d = 2'd0;
                    state_d = StRdWtb;
                end
            end
            StRdWtb: state_d = StRdL;
            StRdL: begin
                wfm_l_d  = wtb_ram_wfm_l_r;
                wfm_r_d  = wtb_ram_wfm_r_r;
                factor_d = wtb_ram_factor_r;
                state_d  = StRdR;
            end
            StRdR: begin
                sample_l_d = wfm_rom_data;
                state_d    = StCalc;
            end
            StCalc: begin
                sample_out_d   = sample_l_q + 8'(prod >>> 8);
                sample_voice_d = voice_q;
                sample_valid_d = 1'b1;
                state_d        = StNext;
            end
            StNext: begin
                if (voice_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    voice_d = voice_q + 2'd1;
                    state_d = StRdWtb;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            pos_q          <= '0;
            phase_q        <= '0;
            voice_q        <= '0;
            wfm_l_q        <= '0;
            wfm_r_q        <= '0;
            factor_q       <= '0;
            sample_l_q     <= '0;
            sample_out_q   <= '0;
            sample_voice_q <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            phase_q        <= phase_d;
            voice_q        <= voice_d;
            wfm_l_q        <= wfm_l_d;
            wfm_r_q        <= wfm_r_d;
            factor_q       <= factor_d;
            sample_l_q     <= sample_l_d;
            sample_out_q   <= sample_out_d;
            sample_voice_q <= sample_voice_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Read ports decode straight from state. The first ROM address uses the RAM
    // data bus directly, since that data only becomes valid during RD_L itself.
    always_comb begin
        wtb_ram_re     = 4'b0000;
        wtb_ram_addr_r = 6'd0;
        wfm_rom_re     = 1'b0;
        wfm_rom_addr   = 16'd0;
        if (state_q == StRdWtb) begin
            wtb_ram_re     = 4'b0001 << voice_q;
            wtb_ram_addr_r = cur_addr;
        end
        if (state_q == StRdL) begin
            wfm_rom_re   = 1'b1;
            wfm_rom_addr = {wtb_ram_wfm_l_r, cur_phase};
        end
        if (state_q == StRdR) begin
            wfm_rom_re   = 1'b1;
            wfm_rom_addr = {wfm_r_q, cur_phase};
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_voice = sample_voice_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_wavetable_reader.sv
// Testbench for wavetable_reader: RAM/ROM behavioural models plus a per-voice
// arithmetic reference of the interpolation, checked cycle by cycle per frame.
module tb_wavetable_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_req = 1'b0;
    logic [23:0] wtb_pos = '0;
    logic [31:0] phase = '0;
    logic [3:0]  wtb_ram_re;
    logic [5:0]  wtb_ram_addr_r;
    logic [7:0]  wtb_ram_wfm_l_r = '0;
    logic [7:0]  wtb_ram_wfm_r_r = '0;
    logic [7:0]  wtb_ram_factor_r = '0;
    logic        wfm_rom_re;
    logic [15:0] wfm_rom_addr;
    logic [7:0]  wfm_rom_data = '0;
    logic [7:0]  sample_out;
    logic [1:0]  sample_voice;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_l[4][61];
    logic [7:0] ram_r[4][61];
    logic [7:0] ram_f[4][61];
    logic [7:0] rom[65536];
    logic [7:0] got_out[4];
    logic [3:0] got_re3;
    logic [5:0] got_addr3;

    wavetable_reader #(.WTB_RAM_SIZE(61)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_req      (sample_req),
        .wtb_pos         (wtb_pos),
        .phase           (phase),
        .wtb_ram_re      (wtb_ram_re),
        .wtb_ram_addr_r  (wtb_ram_addr_r),
        .wtb_ram_wfm_l_r (wtb_ram_wfm_l_r),
        .wtb_ram_wfm_r_r (wtb_ram_wfm_r_r),
        .wtb_ram_factor_r(wtb_ram_factor_r),
        .wfm_rom_re      (wfm_rom_re),
        .wfm_rom_addr    (wfm_rom_addr),
        .wfm_rom_data    (wfm_rom_data),
        .sample_out      (sample_out),
        .sample_voice    (sample_voice),
        .sample_valid    (sample_valid),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory models, one cycle of latency.
    always @(posedge clk) begin
        for (int v = 0; v < 4; v++) begin
            if (wtb_ram_re[v] && wtb_ram_addr_r < 6'd61) begin
                wtb_ram_wfm_l_r  <= ram_l[v][wtb_ram_addr_r];
                wtb_ram_wfm_r_r  <= ram_r[v][wtb_ram_addr_r];
                wtb_ram_factor_r <= ram_f[v][wtb_ram_addr_r];
            end
        end
        if (wfm_rom_re) wfm_rom_data <= rom[wfm_rom_addr];
    end

    // Runs one frame and checks every cycle against the reference model.
    // noisy: toggle sample_req and scramble the position/phase inputs mid-frame.
    task automatic run_frame(input logic [23:0] pos, input logic [31:0] ph, input bit noisy);
        int exp_out[4];
        int exp_addr[4];
        int exp_l[4];
        int exp_r[4];
        int exp_ph[4];
        int v;
        int valid_cnt;
        for (int i = 0; i < 4; i++) begin
            int p, sl, sr;
            p = int'(pos[6*i +: 6]);
            exp_addr[i] = (p > 60) ? 60 : p;
            exp_l[i] = int'(ram_l[i][exp_addr[i]]);
            exp_r[i] = int'(ram_r[i][exp_addr[i]]);
            exp_ph[i] = int'(ph[8*i +: 8]);
            sl = int'(rom[exp_l[i]*256 + exp_ph[i]]);
            sr = int'(rom[exp_r[i]*256 + exp_ph[i]]);
            exp_out[i] = (sl + (((sr - sl) * int'(ram_f[i][exp_addr[i]])) >>> 8)) & 255;
        end
        valid_cnt = 0;
        @(negedge clk);
        wtb_pos = pos;
        phase = ph;
        sample_req = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            v = (c - 1) / 5;
            checks++;
            if (busy !== (c <= 21)) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b want %b", c, busy, (c <= 21));
            end
            checks++;
            if (done !== (c == 21)) begin
                errors++;
                $display("FAIL done cycle %0d: got %b want %b", c, done, (c == 21));
            end
            checks++;
            if (sample_valid !== (c % 5 == 0 && c <= 20)) begin
                errors++;
                $display("FAIL valid cycle %0d: got %b", c, sample_valid);
            end
            if (c % 5 == 0 && c <= 20) begin
                got_out[v] = sample_out;
                valid_cnt++;
                checks++;
                if (sample_voice !== 2'(v) || sample_out !== 8'(exp_out[v])) begin
                    errors++;
                    $display("FAIL sample v%0d: got voice %0d out %h want voice %0d out %h",
                             v, sample_voice, sample_out, v, exp_out[v]);
                end
            end
            if (c % 5 == 1 && c <= 16) begin
                if (v == 3) begin
                    got_re3 = wtb_ram_re;
                    got_addr3 = wtb_ram_addr_r;
                end
                checks++;
                if (wtb_ram_re !== 4'(1 << v) || wtb_ram_addr_r !== 6'(exp_addr[v])) begin
                    errors++;
                    $display("FAIL ram_rd v%0d: got re %b addr %0d want addr %0d",
                             v, wtb_ram_re, wtb_ram_addr_r, exp_addr[v]);
                end
            end else begin
                checks++;
                if (wtb_ram_re !== 4'b0000) begin
                    errors++;
                    $display("FAIL ram_re idle cycle %0d: got %b want 0000", c, wtb_ram_re);
                end
            end
            if ((c % 5 == 2 || c % 5 == 3) && c <= 18) begin
                int w;
                w = (c % 5 == 2) ? exp_l[v] : exp_r[v];
                checks++;
                if (wfm_rom_re !== 1'b1 || wfm_rom_addr !== 16'(w * 256 + exp_ph[v])) begin
                    errors++;
                    $display("FAIL rom_rd cycle %0d: got re %b addr %h want addr %h",
                             c, wfm_rom_re, wfm_rom_addr, w * 256 + exp_ph[v]);
                end
            end else begin
                checks++;
                if (wfm_rom_re !== 1'b0) begin
                    errors++;
                    $display("FAIL rom_re idle cycle %0d: got %b want 0", c, wfm_rom_re);
                end
            end
            if (noisy && c < 20) begin
                sample_req = 1'($urandom_range(0, 1));
                wtb_pos = 24'($urandom);
                phase = $urandom;
            end else begin
                sample_req = 1'b0;
            end
        end
        checks++;
        if (valid_cnt != 4) begin
            errors++;
            $display("FAIL strobe count: got %0d want 4", valid_cnt);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({sample_out, sample_voice, sample_valid, busy, done, wtb_ram_re, wtb_ram_addr_r,
             wfm_rom_re, wfm_rom_addr} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got out %h voice %0d valid %b busy %b done %b re %b addr %0d rre %b raddr %h want all 0",
                     tag, sample_out, sample_voice, sample_valid, busy, done, wtb_ram_re,
                     wtb_ram_addr_r, wfm_rom_re, wfm_rom_addr);
        end
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_interp_directed();
        ram_l[0][10] = 8'd2;  ram_r[0][10] = 8'd5;  ram_f[0][10] = 8'h80;
        rom[16'h0240] = 8'h20; rom[16'h0540] = 8'hA0;
        ram_l[1][20] = 8'd7;  ram_r[1][20] = 8'd8;  ram_f[1][20] = 8'h40;
        rom[16'h0711] = 8'hA0; rom[16'h0811] = 8'h20;
        ram_l[2][30] = 8'd9;  ram_r[2][30] = 8'd9;  ram_f[2][30] = 8'h00;
        rom[16'h0922] = 8'hA0;
        ram_l[3][60] = 8'd1;  ram_r[3][60] = 8'd3;  ram_f[3][60] = 8'hFF;
        run_frame({6'd63, 6'd30, 6'd20, 6'd10}, 32'h33221140, 1'b0);
        checks++;
        if (got_out[0] !== 8'h60) begin
            errors++;
            $display("FAIL interp_up: got %h want 60", got_out[0]);
        end
        checks++;
        if (got_out[1] !== 8'h80) begin
            errors++;
            $display("FAIL interp_down: got %h want 80", got_out[1]);
        end
        checks++;
        if (got_out[2] !== 8'hA0) begin
            errors++;
            $display("FAIL factor_zero: got %h want a0", got_out[2]);
        end
        checks++;
        if (got_re3 !== 4'b1000 || got_addr3 !== 6'd60) begin
            errors++;
            $display("FAIL clamp: got re %b addr %0d want re 1000 addr 60", got_re3, got_addr3);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) run_frame(24'($urandom), $urandom, 1'b0);
    endtask

    task automatic test_ignored_req();
        run_frame(24'($urandom), $urandom, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL extra_frame: got busy %b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        wtb_pos = 24'($urandom);
        phase = $urandom;
        sample_req = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            sample_req = 1'b0;
        end
        checks++;
        if (wfm_rom_re !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got rom_re %b busy %b want 1 1", wfm_rom_re, busy);
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (sample_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got valid %b busy %b want 0 0",
                         c, sample_valid, busy);
            end
        end
        run_frame(24'($urandom), $urandom, 1'b0);
    endtask

    initial begin
        for (int v = 0; v < 4; v++) begin
            for (int a = 0; a < 61; a++) begin
                ram_l[v][a] = 8'($urandom);
                ram_r[v][a] = 8'($urandom);
                ram_f[v][a] = 8'($urandom);
            end
        end
        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        test_reset();
        test_interp_directed();
        test_random();
        test_ignored_req();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wavetable_reader.md
WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
REQ-001 Parameter: WTB_RAM_SIZE, default 61, number of wavetable RAM entries per voice; the highest valid address is WTB_RAM_SIZE-1.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: sample_req  in  1  start one frame (4 voices); sampled only in IDLE.
REQ-005 Port: wtb_pos  in  24  per-voice wavetable position; voice v occupies bits [6v+5:6v].
REQ-006 Port: phase  in  32  per-voice waveform phase; voice v occupies bits [8v+7:8v].
REQ-007 Port: wtb_ram_re  out  4  one-hot read enable; bit v selects voice v's RAM.
REQ-008 Port: wtb_ram_addr_r  out  6  wavetable RAM read address.
REQ-009 Port: wtb_ram_wfm_l_r / wtb_ram_wfm_r_r / wtb_ram_factor_r  in  8 each  RAM read data; valid 1 cycle after re.
REQ-010 Port: wfm_rom_re  out  1  waveform sample ROM read enable.
REQ-011 Port: wfm_rom_addr  out  16  {waveform index[7:0], phase[7:0]}.
REQ-012 Port: wfm_rom_data  in  8  unsigned sample; valid 1 cycle after re.
REQ-013 Port: sample_out  out  8  interpolated unsigned sample.
REQ-014 Port: sample_voice  out  2  voice index of sample_out.
REQ-015 Port: sample_valid  out  1  one-cycle strobe qualifying sample_out and sample_voice.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: done  out  1  one-cycle pulse at frame end.

Function
REQ-018 States SHALL be IDLE, RD_WTB, RD_L, RD_R, CALC, NEXT, DONE.
REQ-019 In IDLE, sample_req=1 SHALL latch wtb_pos and phase, clear voice counter to 0, and go to RD_WTB; sample_req is ignored in all other states.
REQ-020 RD_WTB SHALL assert wtb_ram_re[voice] with wtb_ram_addr_r = min(wtb_pos[voice], WTB_RAM_SIZE-1), then go to RD_L.
REQ-021 RD_L SHALL capture wfm_l, wfm_r and factor from RAM, and issue a ROM read at {wfm_l, phase[voice]}.
REQ-022 RD_R SHALL capture wfm_rom_data as sample_l and issue a ROM read at {wfm_r, phase[voice]}.
REQ-023 CALC SHALL take wfm_rom_data as sample_r and register sample_out = sample_l + ((sample_r - sample_l) * factor) >>> 8, using a 9-bit signed difference, an 18-bit signed product, and arithmetic shift; the result is always 0..255 and no saturation is needed.
REQ-024 sample_valid SHALL be high for exactly the one cycle after CALC, with sample_voice = voice.
REQ-025 NEXT SHALL go to DONE when voice==3; otherwise it increments voice and returns to RD_WTB.
REQ-026 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-027 Timing: 5 cycles per voice; done is high in the 21st cycle after the IDLE-exit edge; busy is high throughout.
REQ-028 With factor=0, sample_out SHALL equal sample_l; with wfm_l==wfm_r, both ROM reads are still performed.
REQ-029 wtb_ram_re and wfm_rom_re SHALL be 0 in every state other than the one issuing that read.
REQ-030 The block SHALL issue only reads; concurrent loader writes to the same RAM entry return whichever data the RAM delivers, with no stalling.

Reset
REQ-031 rst=1 SHALL force IDLE immediately, including mid-frame.
REQ-032 On reset, every output SHALL be 0: sample_out, sample_voice, sample_valid, busy, done, wtb_ram_re, wtb_ram_addr_r, wfm_rom_re, wfm_rom_addr.
REQ-033 On reset, all latched positions, phases, voice counter and capture registers SHALL clear to 0.
REQ-034 The first sample_req after rst deasserts SHALL start a normal frame.

Verification
REQ-035 Interpolation up: voice0 pos=10, RAM[10]={l=2, r=5, f=0x80}, phase0=0x40, ROM{2,40}=0x20, ROM{5,40}=0xA0 -> addr_r=10, re=0001, sample_out=0x60, sample_voice=0.
REQ-036 Interpolation down: l sample=0xA0, r sample=0x20, f=0x40 -> sample_out=0x80; f=0x00 -> sample_out=0xA0.
REQ-037 Clamp and one-hot: voice3 pos=63 -> wtb_ram_addr_r=60 with wtb_ram_re=1000.
REQ-038 Full frame: one sample_req -> four sample_valid strobes, voices 0,1,2,3 in order, 5 cycles apart; done in cycle 21; busy high for 21 cycles.
REQ-039 Ignored request: sample_req pulsed repeatedly while busy -> exactly one frame, values unchanged from latched inputs.
REQ-040 Mid-frame reset: rst asserted in RD_R of voice 2 -> all outputs 0 at once, no further sample_valid; a new sample_req then completes a full frame.
